// File: rtl/ace_ccu_snoop_collector.sv
// Snoop response collector: tracks dispatched snoops in order and merges per-port CRs into one response per entry.
// Latency: cr_valid_o is registered, one cycle after the last CR handshake (or after the push of an empty-mask entry).
// Backpressure: ctrl_ready_o drops when all Depth entries are used; per-port CRs are stalled unless pending at the head.
// Optional watchdog via `define ACE_CCU_SNOOP_TIMEOUT_EN.
module ace_ccu_snoop_collector #(
    parameter int unsigned NumInp        = 4,
    parameter int unsigned NumOup        = 4,
    parameter int unsigned Depth         = 4,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned IdxW         = (NumInp > 1) ? $clog2(NumInp) : 1,
    localparam int unsigned AW           = $clog2(Depth)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ctrl_valid_i,
    output logic                    ctrl_ready_o,
    input  logic [NumOup-1:0]       ctrl_sel_i,
    input  logic [IdxW-1:0]         ctrl_idx_i,
    input  logic [NumOup-1:0]       oup_cr_valids_i,
    output logic [NumOup-1:0]       oup_cr_readies_o,
    input  logic [NumOup-1:0][4:0]  oup_cr_resps_i,
    output logic                    cr_valid_o,
    input  logic                    cr_ready_i,
    output logic [4:0]              cr_resp_o,
    output logic [IdxW-1:0]         cr_idx_o,
    output logic [AW:0]             usage_o,
    output logic                    timeout_o
);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("Depth must be a power of two and at least 2");
    end
    if (NumOup < 1 || NumOup > 32) begin : g_bad_oup
        $error("NumOup must be in 1..32");
    end
    if (TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_bad_timeout
        $error("TimeoutCycles must be in 1..65535");
    end

    logic [NumOup-1:0] pend_q [Depth];
    logic [4:0]        resp_q [Depth];
    logic [IdxW-1:0]   idx_q  [Depth];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [AW:0]       usage_q, usage_nxt;

    logic              cr_valid_q;
    logic [4:0]        cr_resp_q;
    logic [IdxW-1:0]   cr_idx_q;

    logic              empty, full, push, pop, fire;
    logic [NumOup-1:0] readies, hs, head_pend_upd, nh_pend;
    logic [4:0]        merged, head_resp_upd, nh_resp;
    logic [IdxW-1:0]   nh_idx;
    logic              nh_valid, nh_done;

    assign empty = (usage_q == '0);
    assign full  = (usage_q == (AW+1)'(Depth));
    assign push  = ctrl_valid_i && !full;
    assign pop   = cr_valid_q && cr_ready_i;

    // Once the head is complete its pending mask is zero, so readies drop by themselves.
    assign readies = empty ? '0 : pend_q[rd_ptr_q];
    assign hs      = oup_cr_valids_i & readies;

    always_comb begin
        merged = '0;
        for (int j = 0; j < NumOup; j++) begin
            if (hs[j]) merged = merged | oup_cr_resps_i[j];
        end
    end

    assign head_pend_upd = pend_q[rd_ptr_q] & ~hs & {NumOup{~fire}};
    assign head_resp_upd = resp_q[rd_ptr_q] | merged | {3'b000, fire, 1'b0};

    assign rd_ptr_nxt = rd_ptr_q + AW'(pop);
    assign usage_nxt  = usage_q + (AW+1)'(push) - (AW+1)'(pop);

    // Head as it will look after this edge; completion is registered from it so
    // cr_valid_o rises in the cycle right after the finishing event.
    always_comb begin
        nh_pend = pend_q[rd_ptr_nxt];
        nh_resp = resp_q[rd_ptr_nxt];
        nh_idx  = idx_q[rd_ptr_nxt];
        if (push && rd_ptr_nxt == wr_ptr_q) begin
            nh_pend = ctrl_sel_i;
            nh_resp = '0;
            nh_idx  = ctrl_idx_i;
        end else if (!pop) begin
            nh_pend = head_pend_upd;
            nh_resp = head_resp_upd;
        end
    end

    assign nh_valid = (usage_nxt != '0);
    assign nh_done  = nh_valid && (nh_pend == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                pend_q[i] <= '0;
                resp_q[i] <= '0;
                idx_q[i]  <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usage_q    <= '0;
            cr_valid_q <= 1'b0;
            cr_resp_q  <= '0;
            cr_idx_q   <= '0;
        end else begin
            if (push) begin
                pend_q[wr_ptr_q] <= ctrl_sel_i;
                resp_q[wr_ptr_q] <= '0;
                idx_q[wr_ptr_q]  <= ctrl_idx_i;
            end
            if (!empty && !pop) begin
                pend_q[rd_ptr_q] <= head_pend_upd;
                resp_q[rd_ptr_q] <= head_resp_upd;
            end
            wr_ptr_q   <= wr_ptr_q + AW'(push);
            rd_ptr_q   <= rd_ptr_nxt;
            usage_q    <= usage_nxt;
            cr_valid_q <= nh_done;
            if (nh_done) begin
                cr_resp_q <= nh_resp;
                cr_idx_q  <= nh_idx;
            end
        end
    end

`ifdef ACE_CCU_SNOOP_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        timeout_q;

    // Fires on the cycle the count would reach TimeoutCycles, so the pulse lands
    // exactly TimeoutCycles edges after the last progress.
    assign fire = !empty && !cr_valid_q && (hs == '0) && (wd_q == 16'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= fire;
            if (empty || cr_valid_q || hs != '0 || fire) wd_q <= '0;
            else                                         wd_q <= wd_q + 16'd1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign fire      = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign ctrl_ready_o     = !full;
    assign oup_cr_readies_o = readies;
    assign cr_valid_o       = cr_valid_q;
    assign cr_resp_o        = cr_resp_q;
    assign cr_idx_o         = cr_idx_q;
    assign usage_o          = usage_q;

endmodule
